// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - fetch-stage bundle: imem address/data, decoder controls, PC and status
// Optional PC_RETIRE_CNT_EN adds the retired-instruction count.
interface pc_fetch_if;
    logic        en;
    logic        halt_req;
    logic [31:0] instr_in;
    logic        Jump;
    logic        Branch;
    logic        BneBeq;
    logic        IsJAL;
    logic        jr;
    logic        zero;
    logic [31:0] rs_data;
    logic [31:0] imem_addr;
    logic        op0;
    logic        op1;
    logic        op2;
    logic        op3;
    logic        op4;
    logic        op5;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
`ifdef PC_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    modport master (
        input  en, halt_req, instr_in, Jump, Branch, BneBeq, IsJAL, jr, zero, rs_data,
        output imem_addr, op0, op1, op2, op3, op4, op5, pc, pc_plus4, fetch_valid, halted
`ifdef PC_RETIRE_CNT_EN
        , output retired
`endif
    );

    modport slave (
        output en, halt_req, instr_in, Jump, Branch, BneBeq, IsJAL, jr, zero, rs_data,
        input  imem_addr, op0, op1, op2, op3, op4, op5, pc, pc_plus4, fetch_valid, halted
`ifdef PC_RETIRE_CNT_EN
        , input retired
`endif
    );
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - PC register, next-PC select, opcode split and run/halt FSM
// Optional PC_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_if.master     bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] pc_next;
    logic        branch_taken;
    logic        pc_load;
    logic        retire_inc;
    logic        fetch_valid;
    logic        halted;

    // IsJAL only matters on the link path; word-aligned jr drops rs_data[1:0].
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.IsJAL, bus.rs_data[1:0]};

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_off    = {{14{bus.instr_in[15]}}, bus.instr_in[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_off;
    assign jump_target   = {pc_plus4[31:28], bus.instr_in[25:0], 2'b00};
    assign jr_target     = {bus.rs_data[31:2], 2'b00};
    assign branch_taken  = bus.Branch & (bus.zero ^ bus.BneBeq);

    always_comb begin
        pc_next = pc_plus4;
        if (bus.jr) begin
            pc_next = jr_target;
        end else if (bus.Jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // The halting instruction still retires, but its successor is never fetched.
    always_comb begin
        state_next  = state;
        fetch_valid = 1'b0;
        halted      = 1'b0;
        pc_load     = 1'b0;
        retire_inc  = 1'b0;
        case (state)
            ST_RUN: begin
                fetch_valid = 1'b1;
                if (bus.en) begin
                    retire_inc = 1'b1;
                    if (bus.halt_req) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (pc_load) begin
            pc_q <= pc_next;
        end
    end

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] retired_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= 32'd0;
        end else if (retire_inc) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.retired = retired_q;
`else
    logic unused_retire;
    assign unused_retire = retire_inc;
`endif

    assign bus.pc          = pc_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fetch_valid;
    assign bus.halted      = halted;
    assign bus.op0         = bus.instr_in[31];
    assign bus.op1         = bus.instr_in[30];
    assign bus.op2         = bus.instr_in[29];
    assign bus.op3         = bus.instr_in[28];
    assign bus.op4         = bus.instr_in[27];
    assign bus.op5         = bus.instr_in[26];

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch and next-PC stage of the single-cycle MIPS core. Holds the program counter, drives the instruction-memory address, and splits the fetched word's opcode into the one-bit `op0`..`op5` inputs of the opcode decoder. It then consumes the decoder's `Jump`/`Branch`/`BneBeq`/`IsJAL` controls plus the ALU zero flag to select the next PC. A small run/halt state machine stops fetching on a halt request.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_3000`: PC value loaded while reset is asserted.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `en`  in  1  advance enable; 0 = stall (PC, state and counter hold).
- `halt_req`  in  1  halt request for the current instruction, e.g. from syscall detection.
- `instr_in`  in  32  word read combinationally at `imem_addr`.
- `Jump`, `Branch`, `BneBeq`, `IsJAL`, `jr`  in  1 each  decoder controls. `BneBeq`=1 means bne.
- `zero`  in  1  ALU equality flag.
- `rs_data`  in  32  register-file rs value (jr target).
- `imem_addr`  out  32  equals `pc`.
- `op0`..`op5`  out  1 each  `instr_in[31]`..`instr_in[26]`; `op0` is the MSB.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4` (JAL link value).
- `fetch_valid`  out  1  1 in RUN; writers gate on it.
- `halted`  out  1  1 in HALT.
- `retired`  out  32  retired-instruction count (only with `PC_RETIRE_CNT_EN`).

## Operation
- States:
  - RUN: reset state, `fetch_valid`=1.
  - HALT: `halted`=1, `fetch_valid`=0.
- Reset (`rst_n`=0 at an edge), from any state: `pc`←`RESET_PC`, state←RUN, `retired`←0.
- Reset values of outputs: `pc`=`imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC+4`, `fetch_valid`=1, `halted`=0, `retired`=0.
- `pc_plus4` = `pc + 4`, modulo 2^32. `32'hFFFF_FFFC` wraps to 0.
- Next-PC selection, highest priority first:
  - `jr`=1: `{rs_data[31:2], 2'b00}`. Low bits are cleared silently.
  - `Jump`=1 (j and jal): `{pc_plus4[31:28], instr_in[25:0], 2'b00}`.
  - `Branch & (zero ^ BneBeq)`: `pc_plus4 + {{14{instr_in[15]}}, instr_in[15:0], 2'b00}`, modulo 2^32.
  - Otherwise: `pc_plus4`.
- `IsJAL` does not affect the next PC. It is accepted for the link path only; `pc_plus4` is the value written to $31.
- RUN, `en`=1, `halt_req`=0: `pc`←next-PC; `retired` increments.
- RUN, `en`=1, `halt_req`=1: `pc` holds; state→HALT. `retired` increments, because the halting instruction is counted.
- RUN, `en`=0: everything holds; `halt_req` is ignored.
- HALT: everything holds regardless of `en`, `halt_req` and the controls. HALT is exited only by reset.
- `op0`..`op5` follow `instr_in` combinationally in every state. Downstream gating uses `fetch_valid`.

## Timing
- Next-PC logic is combinational from `pc`, `instr_in` and the controls; a single-cycle path.
- PC update latency: one edge. A value selected in cycle N appears on `pc` in cycle N+1.
- `halted` rises on the edge that samples `halt_req`=1 with `en`=1.
- Reset and `en`=1 at the same edge: reset wins.
- Reset and `halt_req` at the same edge: reset wins; state is RUN.
- `rst_n` deasserted: first fetch is from `RESET_PC` in the following cycle.
- `retired` wraps from `32'hFFFF_FFFF` to 0.

## Configuration
- `PC_RETIRE_CNT_EN` defined: 32-bit `retired` counter and port are present, with the behaviour above.
- `PC_RETIRE_CNT_EN` not defined: counter and port are removed. All other behaviour is identical.

## Test plan
- Reset: `rst_n`=0 for 2 edges with `RESET_PC`=`0x3000` → `pc`=`0x3000`, `pc_plus4`=`0x3004`, `halted`=0, `fetch_valid`=1, `retired`=0.
- Sequential fetch and stall:
  - addi with no controls → `pc` goes `0x3000`→`0x3004`→`0x3008`.
  - Hold `en`=0 for 3 cycles → `pc` stays `0x3008`, `retired` stays 2.
- Branches at `pc`=`0x3008`, imm=`0xFFFF`:
  - beq (`Branch`=1, `BneBeq`=0, `zero`=1) → `pc`=`0x3008`.
  - bne (`BneBeq`=1, `zero`=1) → `pc`=`0x300C`.
  - bne with `zero`=0 and imm=`0x0004` → `pc`=`0x301C`.
- jal at `pc`=`0x3010` with `instr_in[25:0]`=`0x0000C10` → `pc`=`0x0000_3040`; `pc_plus4` was `0x3014` during the jal cycle.
- jr priority: `jr`=1, `Jump`=1, `rs_data`=`0x3023` → `pc`=`0x3020`.
- Halt and recovery:
  - `halt_req`=1 at `pc`=`0x3018` → next cycle `halted`=1, `fetch_valid`=0, `pc` stays `0x3018` for 5 cycles with toggling controls, `retired` frozen.
  - `rst_n`=0 for 1 edge → RUN, `pc`=`0x3000`.
